// File: rtl/key_scan_debounce.sv
// Four-key debouncer with one-cycle press, release and long-press pulses.
// A short press toggles that key's LED; any long press turns all LEDs off.
//
// state     | meaning
// IDLE      | key released and debounced
// PRESS_DEB | raw low seen, counting stable cycles before accepting the press
// HELD      | press accepted, counting toward the long-press pulse
// REL_DEB   | raw high seen while held, counting stable cycles before release
module key_scan_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic       FPGA_CLK,
  input  logic       RST_N,
  input  logic [3:0] KEY,
  output logic [3:0] KEY_STATE,
  output logic [3:0] KEY_PRESS,
  output logic [3:0] KEY_RELEASE,
  output logic [3:0] KEY_LONG,
  output logic [3:0] LED
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} key_st_t;

  logic [3:0]    s1;
  logic [3:0]    s2;
  key_st_t       st   [4];
  logic [DW-1:0] dcnt [4];
  logic [HW-1:0] hcnt [4];
  logic [3:0]    long_fired;
  logic [3:0]    rel_hit;
  logic [3:0]    long_hit;
  logic [3:0]    toggle;
  logic          clear;

  // Decisions shared by the per-key FSMs and the LED register.
  always_comb begin
    rel_hit  = '0;
    long_hit = '0;
    for (int i = 0; i < 4; i++) begin
      rel_hit[i]  = (st[i] == REL_DEB) && s2[i] && (dcnt[i] == D_LAST);
      long_hit[i] = (st[i] == HELD) && !s2[i] && !long_fired[i] &&
                    (hcnt[i] == H_LAST);
    end
    toggle = rel_hit & ~long_fired;
    clear  = |long_hit;
  end

  always_ff @(posedge FPGA_CLK) begin
    if (!RST_N) begin
      s1          <= 4'b1111;
      s2          <= 4'b1111;
      long_fired  <= '0;
      KEY_STATE   <= '0;
      KEY_PRESS   <= '0;
      KEY_RELEASE <= '0;
      KEY_LONG    <= '0;
      LED         <= 4'b1111;
      for (int i = 0; i < 4; i++) begin
        st[i]   <= IDLE;
        dcnt[i] <= '0;
        hcnt[i] <= '0;
      end
    end else begin
      s1          <= KEY;
      s2          <= s1;
      KEY_PRESS   <= '0;
      KEY_RELEASE <= '0;
      KEY_LONG    <= '0;
      LED         <= clear ? 4'b1111 : (LED ^ toggle);
      for (int i = 0; i < 4; i++) begin
        case (st[i])
          IDLE: begin
            if (!s2[i]) begin
              st[i]   <= PRESS_DEB;
              dcnt[i] <= '0;
            end
          end
          PRESS_DEB: begin
            if (s2[i]) begin
              st[i] <= IDLE;
            end else if (dcnt[i] == D_LAST) begin
              st[i]         <= HELD;
              KEY_PRESS[i]  <= 1'b1;
              KEY_STATE[i]  <= 1'b1;
              hcnt[i]       <= '0;
              long_fired[i] <= 1'b0;
            end else begin
              dcnt[i] <= dcnt[i] + DW'(1);
            end
          end
          HELD: begin
            if (s2[i]) begin
              st[i]   <= REL_DEB;
              dcnt[i] <= '0;
            end else if (long_hit[i]) begin
              KEY_LONG[i]   <= 1'b1;
              long_fired[i] <= 1'b1;
            end else if (!long_fired[i]) begin
              hcnt[i] <= hcnt[i] + HW'(1);
            end
          end
          REL_DEB: begin
            // A bounce back to low resumes the hold count where it left off.
            if (!s2[i]) begin
              st[i] <= HELD;
            end else if (rel_hit[i]) begin
              st[i]          <= IDLE;
              KEY_RELEASE[i] <= 1'b1;
              KEY_STATE[i]   <= 1'b0;
            end else begin
              dcnt[i] <= dcnt[i] + DW'(1);
            end
          end
          default: st[i] <= IDLE;
        endcase
      end
    end
  end

endmodule
